// File: rtl/clock_div_multi.sv
// clock_div_multi: multi-channel programmable 50% clock divider with tick enables
//
// Runs CHANNELS independent dividers from clk_in. Each channel has its own
// half-period register and can be reprogrammed through a single shared
// config slot. New values are applied only at the end of a full period, so
// the divided clock never glitches.
//
// Optional feature macro: CLOCK_DIV_SYNC_EN adds the sync_in port, which
// phase-aligns every channel. Without it, channels align only at reset.
//
// Parameters:
//   CHANNELS      number of divider channels (1..16)
//   CNT_W         width of the half-period value and the counters
//   DEFAULT_HALF  half-period loaded into every channel at reset
//
// Ports:
//   clk_in        input clock, rising edge
//   rst_n_in      synchronous reset, active-low
//   en_in         per-channel run enable
//   cfg_valid_in  config write request
//   cfg_ready_out config slot free; write accepted when valid && ready
//   cfg_chan_in   target channel of the config write
//   cfg_half_in   new half-period for the target channel
//   sync_in       phase-align all channels (CLOCK_DIV_SYNC_EN only)
//   clk_out       divided square outputs, period 2*half
//   tick_out      one-cycle pulse coincident with each clk_out rise
module clock_div_multi #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 1,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [CHANNELS-1:0] en_in,
    input  logic                cfg_valid_in,
    output logic                cfg_ready_out,
    input  logic [CW-1:0]       cfg_chan_in,
    input  logic [CNT_W-1:0]    cfg_half_in,
`ifdef CLOCK_DIV_SYNC_EN
    input  logic                sync_in,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick_out
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d, half_q, half_d;
    logic [CHANNELS-1:0]            clk_q, clk_d, tick_q, tick_d;
    logic [CHANNELS-1:0]            last, app;
    logic                           pend_q, pend_d;
    logic [CW-1:0]                  pchan_q, pchan_d;
    logic [CNT_W-1:0]               phalf_q, phalf_d;
    logic                           sync;

`ifdef CLOCK_DIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    assign clk_out       = clk_q;
    assign tick_out      = tick_q;
    assign cfg_ready_out = ~pend_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt_q   <= '0;
            half_q  <= {CHANNELS{HALF_RST}};
            clk_q   <= '0;
            tick_q  <= '0;
            pend_q  <= 1'b0;
            pchan_q <= '0;
            phalf_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            pchan_q <= pchan_d;
            phalf_q <= phalf_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        half_d  = half_q;
        clk_d   = clk_q;
        tick_d  = '0;
        pend_d  = pend_q;
        pchan_d = pchan_q;
        phalf_d = phalf_q;
        last    = '0;
        app     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            last[i] = cnt_q[i] == half_q[i] - ONE;
            // A pending write lands at the end of the high phase (the point
            // where clk_out would fall anyway), or at once if the channel is
            // idle or a sync is in progress.
            app[i] = pend_q && int'(pchan_q) == i &&
                     (sync || !en_in[i] || half_q[i] == '0 || (last[i] && clk_q[i]));
            if (app[i]) begin
                half_d[i] = phalf_q;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
            end else if (sync || half_q[i] == '0) begin
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
            end else if (en_in[i]) begin
                cnt_d[i]  = last[i] ? '0 : cnt_q[i] + ONE;
                clk_d[i]  = clk_q[i] ^ last[i];
                tick_d[i] = last[i] & ~clk_q[i];
            end
        end
        // Out-of-range targets are simply dropped one cycle after acceptance.
        if (pend_q && (sync || |app || int'(pchan_q) >= CHANNELS))
            pend_d = 1'b0;
        if (cfg_valid_in && !pend_q) begin
            pend_d  = 1'b1;
            pchan_d = cfg_chan_in;
            phalf_d = cfg_half_in;
        end
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi: directed vector bench for clock_div_multi (CHANNELS=2, DEFAULT_HALF=1)
module tb_clock_div_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_chan;
    logic [7:0] cfg_half;
    logic [1:0] clk_o;
    logic [1:0] tick_o;
`ifdef CLOCK_DIV_SYNC_EN
    logic       sync;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    clock_div_multi #(.CHANNELS(2), .CNT_W(8), .DEFAULT_HALF(1)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .en_in(en),
        .cfg_valid_in(cfg_valid),
        .cfg_ready_out(cfg_ready),
        .cfg_chan_in(cfg_chan),
        .cfg_half_in(cfg_half),
`ifdef CLOCK_DIV_SYNC_EN
        .sync_in(sync),
`endif
        .clk_out(clk_o),
        .tick_out(tick_o)
    );

    typedef struct {
        logic [1:0] en;
        logic       v;
        logic       ch;
        logic [7:0] half;
        logic [1:0] clk;
        logic [1:0] tick;
        logic       rdy;
    } vec_t;

    vec_t tbl [31];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic ch, input logic [7:0] h);
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_half  = h;
    endtask

    initial begin
        // cols: en, valid, chan, half | clk_out, tick_out, ready
        tbl[0]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 1'b1};
        tbl[1]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[2]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 1'b1};
        tbl[3]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[4]  = '{2'b11, 1'b1, 1'b1, 8'd3, 2'b11, 2'b11, 1'b0};
        tbl[5]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[6]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01, 1'b1};
        tbl[7]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[8]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 1'b1};
        tbl[9]  = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1};
        tbl[10] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b01, 1'b1};
        tbl[11] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[12] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01, 1'b1};
        tbl[13] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[14] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 1'b1};
        tbl[15] = '{2'b11, 1'b1, 1'b0, 8'd0, 2'b10, 2'b00, 1'b0};
        tbl[16] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b01, 1'b0};
        tbl[17] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[18] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[19] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[20] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b10, 1'b1};
        tbl[21] = '{2'b10, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1};
        tbl[22] = '{2'b10, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1};
        tbl[23] = '{2'b11, 1'b1, 1'b0, 8'd2, 2'b00, 2'b00, 1'b0};
        tbl[24] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[25] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[26] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 1'b1};
        tbl[27] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b00, 1'b1};
        tbl[28] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1};
        tbl[29] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1};
        tbl[30] = '{2'b11, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01, 1'b1};

        rst_n     = 1'b0;
        en        = 2'b11;
        cfg_valid = 1'b0;
        cfg_chan  = 1'b0;
        cfg_half  = 8'd0;
`ifdef CLOCK_DIV_SYNC_EN
        sync      = 1'b0;
`endif
        step();
        step();
        chk("reset clk_out", 32'(clk_o), 32'h0);
        chk("reset tick_out", 32'(tick_o), 32'h0);
        chk("reset ready", 32'(cfg_ready), 32'h1);

        // Default half=1, half=3 reprogram, half=0 stop, restart at half=2
        rst_n = 1'b1;
        for (int i = 0; i < 31; i++) begin
            en        = tbl[i].en;
            cfg_valid = tbl[i].v;
            cfg_chan  = tbl[i].ch;
            cfg_half  = tbl[i].half;
            step();
            chk($sformatf("vec%0d clk_out", i), 32'(clk_o), 32'(tbl[i].clk));
            chk($sformatf("vec%0d tick_out", i), 32'(tick_o), 32'(tbl[i].tick));
            chk($sformatf("vec%0d ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
        end
        cfg_valid = 1'b0;

        // Freeze: ch1 idle so half=4 applies at once, run to cnt=2, hold 5 cycles
        en = 2'b01;
        wr(1'b1, 8'd4);
        step();
        cfg_valid = 1'b0;
        chk("frz accept ready", 32'(cfg_ready), 32'h0);
        step();
        chk("frz apply ready", 32'(cfg_ready), 32'h1);
        chk("frz apply clk1", 32'(clk_o[1]), 32'h0);
        en = 2'b11;
        step();
        step();
        chk("frz run clk1", 32'(clk_o[1]), 32'h0);
        en = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("frz hold%0d clk1", i), 32'(clk_o[1]), 32'h0);
            chk($sformatf("frz hold%0d tick1", i), 32'(tick_o[1]), 32'h0);
        end
        en = 2'b11;
        step();
        chk("frz resume1 clk1", 32'(clk_o[1]), 32'h0);
        chk("frz resume1 tick1", 32'(tick_o[1]), 32'h0);
        step();
        chk("frz resume2 clk1", 32'(clk_o[1]), 32'h1);
        chk("frz resume2 tick1", 32'(tick_o[1]), 32'h1);

        // Same-value write still waits for the end of the high phase (3 more cycles)
        wr(1'b1, 8'd4);
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("same wait%0d ready", i), 32'(cfg_ready), 32'h0);
            chk($sformatf("same wait%0d clk1", i), 32'(clk_o[1]), 32'h1);
        end
        step();
        chk("same apply ready", 32'(cfg_ready), 32'h1);
        chk("same apply clk1", 32'(clk_o[1]), 32'h0);

`ifdef CLOCK_DIV_SYNC_EN
        en = 2'b00;
        wr(1'b0, 8'd2);
        step();
        cfg_valid = 1'b0;
        step();
        wr(1'b1, 8'd4);
        step();
        cfg_valid = 1'b0;
        step();
        en = 2'b11;
        step();
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync clk_out", 32'(clk_o), 32'h0);
        chk("sync tick_out", 32'(tick_o), 32'h0);
        begin
            logic [1:0] sc [4];
            logic [1:0] st [4];
            sc = '{2'b00, 2'b01, 2'b01, 2'b10};
            st = '{2'b00, 2'b01, 2'b00, 2'b10};
            for (int i = 0; i < 4; i++) begin
                step();
                chk($sformatf("sync+%0d clk_out", i + 1), 32'(clk_o), 32'(sc[i]));
                chk($sformatf("sync+%0d tick_out", i + 1), 32'(tick_o), 32'(st[i]));
            end
        end
`endif

        // Reset with a write pending: write is dropped, defaults restored
        en = 2'b11;
        wr(1'b1, 8'd7);
        step();
        cfg_valid = 1'b0;
        chk("rst pend ready", 32'(cfg_ready), 32'h0);
        rst_n = 1'b0;
        step();
        chk("rst mid clk_out", 32'(clk_o), 32'h0);
        chk("rst mid tick_out", 32'(tick_o), 32'h0);
        chk("rst mid ready", 32'(cfg_ready), 32'h1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst post%0d clk_out", i), 32'(clk_o), (i % 2 == 0) ? 32'h3 : 32'h0);
            chk($sformatf("rst post%0d ready", i), 32'(cfg_ready), 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
